lab_a2_scan_ctrl: RTL
=====================

// Module: lab_a2_scan_ctrl
// PURPOSE
//  Scan controller for the signed 3-bit adder display. Latches operands a/b on a load strobe.
//  Computes the sign-magnitude sum. Time-shares one 8-bit segment bus between two tubes:
//  digit 0 shows the sign, digit 1 shows the magnitude. A blanking gap between digits prevents ghosting.
//  Sits between the switch inputs and the board's tub select/segment pins.
// PARAMETERS
//  SCAN_DIV   100000  clk cycles each digit is driven (>=2); 1 kHz/digit at 100 MHz
//  BLANK_CYC  16      clk cycles of all-off between digits (>=1)
// PORTS
//  clk      in   1  system clock, single clock domain
//  rst_n    in   1  asynchronous active-low reset
//  en       in   1  display enable; 0 = blank and hold scan
//  load     in   1  single-cycle strobe; captures a, b
//  a        in   3  operand, two's complement (-4..3)
//  b        in   3  operand, two's complement (-4..3)
//  tub_sel  out  2  one-hot, active-high tub select; [0]=sign, [1]=magnitude
//  tub_ctrl out  8  segments {a,b,c,d,e,f,g,dp}, active high
// BEHAVIOUR
//  Reset:
//   - tub_sel=0, tub_ctrl=0, operand regs=0.
//   - FSM=BLANK1, counter=0.
//  Operand capture:
//   - load=1 registers a,b at the next edge.
//   - sum = sext(a)+sext(b), 4-bit signed, range -8..6; no overflow possible.
//   - neg = sum<0; mag = |sum|, range 0..8, 4 bits.
//  FSM (Moore): SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0.
//   - SHOW states last SCAN_DIV cycles; BLANK states last BLANK_CYC cycles.
//   - The counter resets on every state change.
//  Digit latch:
//   - neg/mag are sampled into a display register on entry to each SHOW state.
//   - A load mid-digit never alters the digit being shown. The new value appears at the next SHOW entry.
//  Outputs (registered, one cycle after state/counter):
//   - SHOW0: tub_sel=2'b01; tub_ctrl=8'h02 (minus, seg g) if neg, else 8'h00.
//   - SHOW1: tub_sel=2'b10; tub_ctrl=decode(mag).
//   - BLANK*: tub_sel=0, tub_ctrl=0.
//  Decode: 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE; 9..15 -> 00 (unreachable).
//  en=0:
//   - FSM forced to BLANK1 with counter held at 0; outputs blank next cycle.
//   - load still captures operands.
//   - On en rising, SHOW0 follows after BLANK_CYC cycles.
//  Simultaneous events:
//   - rst_n low overrides everything, asynchronously.
//   - load at a SHOW entry edge: the digit uses the OLD operands.
//  Scan period = 2*(SCAN_DIV+BLANK_CYC) cycles. Counter width = $clog2(max(SCAN_DIV,BLANK_CYC)).
// STRUCTURE
//  - Shared header lab_a2_defs.vh: SEG_* digit codes, SEG_MINUS, SEG_OFF, state encodings.
//  - Sub-module lab_a2_seg_decode: 4-bit mag -> 8-bit segments, combinational.
//  - Top holds operand regs, adder/abs, FSM, counter and output regs.
// TESTING (SCAN_DIV=8, BLANK_CYC=2; period 20 cycles)
//  1. Reset: hold rst_n=0 mid-SHOW1 -> tub_sel=0, tub_ctrl=0 immediately. Release -> first tub_sel=01 after 2+1 cycles.
//  2. a=3, b=2, load -> sign tub 00, mag tub B6 (5). Each tub on 8 cycles, 2-cycle gaps of 00/00.
//  3. a=-4, b=-4, load -> sign 02, mag FE (8). a=-1, b=1 -> sign 00, mag FC (0); never "-0".
//  4. Load a=-3, b=0 at cycle 3 of SHOW1 showing 5 -> SHOW1 keeps B6 to its end. Next SHOW0 = 02, SHOW1 = F2.
//  5. en=0 for 30 cycles -> tub_sel=0 throughout. en=1 -> SHOW0 begins after exactly 2 blank cycles.
//  6. Sweep all 64 (a,b) pairs against a reference model of sign/magnitude codes. Assert tub_sel is always one-hot or zero.

Source files
------------

// File: rtl/lab_a2_scan_ctrl_pkg.sv
// Shared types and constants for the signed 3-bit adder scan display.
// Latency: n/a (declarations plus one combinational helper function).
// Backpressure: none; this package holds definitions only.
package lab_a2_scan_ctrl_pkg;

    // Scan FSM states, in the order the scan visits them.
    typedef enum logic [1:0] {
        ST_SHOW0  = 2'd0,
        ST_BLANK0 = 2'd1,
        ST_SHOW1  = 2'd2,
        ST_BLANK1 = 2'd3
    } scan_state_t;

    // One sign-magnitude digit pair as shown on the two tubes.
    typedef struct packed {
        logic       neg;
        logic [3:0] mag;
    } digit_t;

    // Segment codes {a,b,c,d,e,f,g,dp}, active high.
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_MINUS = 8'h02;
    localparam logic [7:0] SEG_OFF   = 8'h00;

    // Tub select patterns.
    localparam logic [1:0] TUB_NONE = 2'b00;
    localparam logic [1:0] TUB_SIGN = 2'b01;
    localparam logic [1:0] TUB_MAG  = 2'b10;

    // Sign-extend both operands to 4 bits and add; -8..6 always fits.
    // Magnitude of -8 is 4'b1000, which reads as unsigned 8.
    function automatic digit_t sm_sum(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        digit_t     d;
        s     = {a[2], a} + {b[2], b};
        d.neg = s[3];
        d.mag = s[3] ? (4'd0 - s) : s;
        return d;
    endfunction

endpackage

// File: rtl/lab_a2_scan_ctrl_if.sv
// Switch-side inputs and tub-side outputs of the scan display controller.
// Latency: n/a (signal bundle only).
// Backpressure: none; load is a fire-and-forget strobe.
// Signals: en, load, a[2:0], b[2:0] toward the controller;
//          tub_sel[1:0], tub_ctrl[7:0] from the controller to the board pins.
interface lab_a2_scan_ctrl_if;
    logic       en;
    logic       load;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tub_sel;
    logic [7:0] tub_ctrl;

    modport master (output en, load, a, b, input tub_sel, tub_ctrl);
    modport slave  (input en, load, a, b, output tub_sel, tub_ctrl);
endinterface

// File: rtl/lab_a2_scan_ctrl_seg_decode.sv
// Magnitude 0..8 to seven-segment pattern; 9..15 blank.
// Latency: combinational.
// Backpressure: none.
// Ports: i_mag[3:0] magnitude in, o_seg[7:0] segment pattern out.
module lab_a2_scan_ctrl_seg_decode
    import lab_a2_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_mag,
    output logic [7:0] o_seg
);
    always_comb begin
        o_seg = SEG_OFF;
        case (i_mag)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            default: o_seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/lab_a2_scan_ctrl.sv
// Latches a/b, forms the sign-magnitude sum, and time-shares one segment bus over sign/magnitude tubes.
// Latency: outputs registered one cycle after FSM state; digit values latched at each SHOW entry.
// Backpressure: none; load always accepted, en=0 blanks the display and parks the scan.
// Ports: clk, rst_n (async active-low); bus (slave): en, load, a, b in; tub_sel, tub_ctrl out.
module lab_a2_scan_ctrl
    import lab_a2_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lab_a2_scan_ctrl_if.slave    bus
);
    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    logic [2:0]  r_op_a;
    logic [2:0]  r_op_b;
    scan_state_t r_state;
    logic [CW-1:0] r_cnt;
    digit_t      r_disp;
    logic [1:0]  r_tub_sel;
    logic [7:0]  r_tub_ctrl;

    digit_t      w_sum;
    logic [7:0]  w_mag_seg;
    logic        w_is_show;
    logic        w_last;

    assign w_sum     = sm_sum(r_op_a, r_op_b);
    assign w_is_show = (r_state == ST_SHOW0) || (r_state == ST_SHOW1);
    assign w_last    = w_is_show ? (r_cnt == SHOW_LAST) : (r_cnt == BLANK_LAST);

    lab_a2_scan_ctrl_seg_decode u_seg_decode (
        .i_mag (r_disp.mag),
        .o_seg (w_mag_seg)
    );

    // Operands are captured regardless of en so the switches can be set while dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= 3'd0;
            r_op_b <= 3'd0;
        end else if (bus.load) begin
            r_op_a <= bus.a;
            r_op_b <= bus.b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BLANK1;
            r_cnt      <= '0;
            r_disp     <= '0;
            r_tub_sel  <= TUB_NONE;
            r_tub_ctrl <= SEG_OFF;
        end else begin
            // Output stage follows the current state; en=0 blanks on the very next edge.
            if (!bus.en) begin
                r_tub_sel  <= TUB_NONE;
                r_tub_ctrl <= SEG_OFF;
            end else begin
                case (r_state)
                    ST_SHOW0: begin
                        r_tub_sel  <= TUB_SIGN;
                        r_tub_ctrl <= r_disp.neg ? SEG_MINUS : SEG_OFF;
                    end
                    ST_SHOW1: begin
                        r_tub_sel  <= TUB_MAG;
                        r_tub_ctrl <= w_mag_seg;
                    end
                    default: begin
                        r_tub_sel  <= TUB_NONE;
                        r_tub_ctrl <= SEG_OFF;
                    end
                endcase
            end

            // Parking in BLANK1 with cnt=0 makes SHOW0 start a full blank gap after en returns.
            if (!bus.en) begin
                r_state <= ST_BLANK1;
                r_cnt   <= '0;
            end else if (w_last) begin
                r_cnt <= '0;
                case (r_state)
                    ST_SHOW0:  r_state <= ST_BLANK0;
                    ST_BLANK0: begin
                        r_state <= ST_SHOW1;
                        // Sampled from pre-edge operands: a coincident load waits a digit.
                        r_disp  <= w_sum;
                    end
                    ST_SHOW1:  r_state <= ST_BLANK1;
                    default: begin
                        r_state <= ST_SHOW0;
                        r_disp  <= w_sum;
                    end
                endcase
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.tub_sel  = r_tub_sel;
    assign bus.tub_ctrl = r_tub_ctrl;

endmodule
